// File: rtl/snake_body.sv
// ---------------------------------------------------------------------------
// snake_body
// Tracks the trailing body of the snake behind the head cell that the
// snakehead stage produces. Every head position is pushed into a circular
// history buffer; the newest MAX_LEN-1 older cells (limited by the current
// body length) form the body. After each move a small FSM walks the body
// one cell per clock, looking for the head overlapping its own body.
//
// Ports:
//   CLOCK_50          system clock
//   reset_n           asynchronous active-low reset
//   move_tick         one-cycle pulse, head has moved to (head_x, head_y)
//   head_x, head_y    new head top-left corner, valid with move_tick
//   grow              one-cycle pulse, food eaten -> body gets longer
//   x, y              current VGA pixel position
//   vga_r/g/b         registered body colour (one cycle after x, y)
//   body_len          body length, head not included
//   busy              collision scan in progress
//   self_hit          sticky self-collision flag
// ---------------------------------------------------------------------------
module snake_body #(
   parameter int MAX_LEN  = 16,
   parameter int SEG_SIZE = 20,
   parameter int INIT_LEN = 3,
   parameter int COORD_W  = 12
) (
   input  logic               CLOCK_50,
   input  logic               reset_n,
   input  logic               move_tick,
   input  logic [COORD_W-1:0] head_x,
   input  logic [COORD_W-1:0] head_y,
   input  logic               grow,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [7:0]         vga_r,
   output logic [7:0]         vga_g,
   output logic [7:0]         vga_b,
   output logic [4:0]         body_len,
   output logic               busy,
   output logic               self_hit
);

   localparam int PTR_W = $clog2(MAX_LEN);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 2 * COORD_W;
   localparam logic [COORD_W:0] SEG_EXT = (COORD_W+1)'(SEG_SIZE);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   logic [ENT_W-1:0] hist_q [MAX_LEN];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] fill_q, fill_d;
   logic [4:0]       len_q, len_d;
   logic [CNT_W-1:0] seg_n;
   logic [CNT_W-1:0] len_ext;

   state_t           state_q;
   logic [CNT_W-1:0] idx_q;
   logic [ENT_W-1:0] head_q;
   logic             busy_q;
   logic             hit_q;

   logic [PTR_W-1:0] age_idx;
   logic             age_match;

   logic [PTR_W-1:0] seg_idx;
   logic [COORD_W:0] sx, sy, px, py;
   logic             in_body;
   logic [7:0]       r_q, g_q, b_q, r_d, g_d, b_d;

   // History memory: plain write port, no reset needed because unused
   // entries are always masked off by the fill count.
   always_ff @(posedge CLOCK_50) begin
      if (move_tick)
         hist_q[wr_ptr_q] <= {head_x, head_y};
   end

   // Next-state for the write pointer, fill level and body length. The
   // pointer wraps naturally through bit truncation; fill and length
   // saturate so the body can never reach back onto the cell being
   // overwritten.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      len_d    = len_q;
      if (move_tick) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (fill_q != CNT_W'(MAX_LEN))
            fill_d = fill_q + 1'b1;
      end
      if (grow && (len_q != 5'(MAX_LEN-1)))
         len_d = len_q + 1'b1;
   end

   // Number of visible body segments: the length is capped by how many
   // older cells actually exist in the buffer (the newest one is the head).
   always_comb begin
      len_ext = CNT_W'(len_q);
      if (fill_q <= CNT_W'(1))
         seg_n = '0;
      else if (len_ext < (fill_q - CNT_W'(1)))
         seg_n = len_ext;
      else
         seg_n = fill_q - CNT_W'(1);
   end

   // Cell currently addressed by the scan, compared against the latched head.
   always_comb begin
      age_idx   = wr_ptr_q - PTR_W'(1) - PTR_W'(idx_q);
      age_match = (hist_q[age_idx] == head_q);
   end

   // Parallel hit test of the pixel against every body segment. The upper
   // bound is formed one bit wider so segments near the coordinate limit
   // do not wrap around to zero.
   always_comb begin
      in_body = 1'b0;
      seg_idx = '0;
      sx      = '0;
      sy      = '0;
      px      = {1'b0, x};
      py      = {1'b0, y};
      for (int k = 0; k < MAX_LEN; k++) begin
         seg_idx = wr_ptr_q - PTR_W'(1) - PTR_W'(k);
         sx      = {1'b0, hist_q[seg_idx][ENT_W-1:COORD_W]};
         sy      = {1'b0, hist_q[seg_idx][COORD_W-1:0]};
         if ((k >= 1) && (CNT_W'(k) <= seg_n) &&
             (px >= sx) && (px < sx + SEG_EXT) &&
             (py >= sy) && (py < sy + SEG_EXT))
            in_body = 1'b1;
      end
      r_d = 8'h00;
      g_d = in_body ? 8'hC0 : 8'h00;
      b_d = 8'h00;
   end

   // Pointer, fill, length and colour registers.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
         len_q    <= 5'(INIT_LEN);
         r_q      <= 8'h00;
         g_q      <= 8'h00;
         b_q      <= 8'h00;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         len_q    <= len_d;
         r_q      <= r_d;
         g_q      <= g_d;
         b_q      <= b_d;
      end
   end

   // Collision scan FSM. A new move always restarts the scan at age 1 with
   // the new head, even mid-scan, so busy never drops between back-to-back
   // moves. A match found in the same cycle as a restart is still a real
   // collision and is recorded.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= CNT_W'(1);
         head_q  <= '0;
         busy_q  <= 1'b0;
         hit_q   <= 1'b0;
      end else if (move_tick) begin
         if ((state_q == SCAN) && (seg_n != '0) && age_match)
            hit_q <= 1'b1;
         state_q <= SCAN;
         idx_q   <= CNT_W'(1);
         head_q  <= {head_x, head_y};
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
            end
            SCAN: begin
               if (seg_n == '0) begin
                  state_q <= DONE;
               end else if (age_match) begin
                  hit_q   <= 1'b1;
                  state_q <= DONE;
               end else if (idx_q >= seg_n) begin
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + CNT_W'(1);
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign vga_r    = r_q;
   assign vga_g    = g_q;
   assign vga_b    = b_q;
   assign body_len = len_q;
   assign busy     = busy_q;
   assign self_hit = hit_q;

endmodule

// File: tb/tb_snake_body.sv
// ---------------------------------------------------------------------------
// tb_snake_body
// Self-checking bench for snake_body. A small reference model (history
// queue, length, sticky hit) predicts how long each collision scan keeps
// busy high and whether it sets self_hit; those predictions are queued when
// a move is driven and popped when the scan ends. Pixel expectations are
// queued when a pixel is driven and popped when the registered colour
// appears one clock later.
// ---------------------------------------------------------------------------
module tb_snake_body;

   localparam int MAX_LEN  = 16;
   localparam int SEG_SIZE = 20;
   localparam int INIT_LEN = 3;
   localparam int COORD_W  = 12;

   logic               CLOCK_50 = 1'b0;
   logic               reset_n;
   logic               move_tick;
   logic [COORD_W-1:0] head_x, head_y;
   logic               grow;
   logic [COORD_W-1:0] x, y;
   logic [7:0]         vga_r, vga_g, vga_b;
   logic [4:0]         body_len;
   logic               busy;
   logic               self_hit;

   int checks = 0;
   int errors = 0;
   int stale;

   logic [23:0] modelHist[$];
   int          modelLen;
   bit          modelHit;
   int          busyQ[$];
   logic [23:0] pixQ[$];

   snake_body #(
      .MAX_LEN (MAX_LEN),
      .SEG_SIZE(SEG_SIZE),
      .INIT_LEN(INIT_LEN),
      .COORD_W (COORD_W)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .move_tick(move_tick),
      .head_x   (head_x),
      .head_y   (head_y),
      .grow     (grow),
      .x        (x),
      .y        (y),
      .vga_r    (vga_r),
      .vga_g    (vga_g),
      .vga_b    (vga_b),
      .body_len (body_len),
      .busy     (busy),
      .self_hit (self_hit)
   );

   // 50 MHz-style free-running clock.
   always #5 CLOCK_50 = ~CLOCK_50;

   // Hard time limit so a stuck DUT can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got stuck expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Number of body segments the model currently shows.
   function automatic int modelN();
      int fill;
      fill = modelHist.size();
      if (fill <= 1) return 0;
      return (modelLen < fill - 1) ? modelLen : fill - 1;
   endfunction

   // Hold reset for two clocks, then release; model and queues restart too.
   task automatic resetDut();
      reset_n   = 1'b0;
      move_tick = 1'b0;
      grow      = 1'b0;
      head_x    = '0;
      head_y    = '0;
      x         = '0;
      y         = '0;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      reset_n = 1'b1;
      modelHist.delete();
      busyQ.delete();
      pixQ.delete();
      modelLen = INIT_LEN;
      modelHit = 1'b0;
      @(negedge CLOCK_50);
   endtask

   // Drive one move (optionally with grow) and queue the predicted scan
   // outcome: busy-high cycle count and sticky hit state.
   task automatic applyStimulus(input int hx, input int hy, input bit g);
      int  n;
      int  expCycles;
      bit  found;
      logic [COORD_W-1:0] hx12, hy12;
      hx12 = hx[COORD_W-1:0];
      hy12 = hy[COORD_W-1:0];
      if (g && modelLen < MAX_LEN - 1) modelLen++;
      modelHist.push_front({hx12, hy12});
      if (modelHist.size() > MAX_LEN) modelHist.delete(MAX_LEN);
      n         = modelN();
      found     = 1'b0;
      expCycles = (n == 0) ? 2 : n + 1;
      for (int k = 1; k <= n; k++) begin
         if (!found && modelHist[k] == modelHist[0]) begin
            found     = 1'b1;
            expCycles = k + 1;
         end
      end
      if (found) modelHit = 1'b1;
      busyQ.push_back(expCycles);
      move_tick = 1'b1;
      head_x    = hx12;
      head_y    = hy12;
      grow      = g;
      @(negedge CLOCK_50);
      move_tick = 1'b0;
      grow      = 1'b0;
   endtask

   // Count busy-high cycles (bounded) and compare against the queued model.
   task automatic waitScan(input string tag);
      int cnt;
      int exp;
      cnt = 0;
      while (busy === 1'b1 && cnt < 64) begin
         cnt++;
         @(negedge CLOCK_50);
      end
      exp = (busyQ.size() > 0) ? busyQ.pop_front() : -1;
      checkOutput({tag, "_busy_cycles"}, cnt, exp);
      checkOutput({tag, "_hit"}, {31'd0, self_hit}, {31'd0, modelHit});
   endtask

   task automatic doMove(input int hx, input int hy, input bit g, input string tag);
      applyStimulus(hx, hy, g);
      waitScan(tag);
   endtask

   task automatic pulseGrow();
      grow = 1'b1;
      if (modelLen < MAX_LEN - 1) modelLen++;
      @(negedge CLOCK_50);
      grow = 1'b0;
   endtask

   // Drive a pixel, queue its expected colour, check it one clock later.
   task automatic probePixel(input int px, input int py, input bit green, input string tag);
      logic [23:0] exp;
      x = px[COORD_W-1:0];
      y = py[COORD_W-1:0];
      exp = green ? 24'h00C000 : 24'h000000;
      pixQ.push_back(exp);
      @(negedge CLOCK_50);
      checkOutput(tag, {8'h00, vga_r, vga_g, vga_b}, {8'h00, pixQ.pop_front()});
   endtask

   initial begin
      // ---- reset state ----
      reset_n   = 1'b0;
      move_tick = 1'b0;
      grow      = 1'b0;
      head_x    = '0;
      head_y    = '0;
      x         = 12'd5;
      y         = 12'd5;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_hit", {31'd0, self_hit}, 32'd0);
      checkOutput("rst_len", {27'd0, body_len}, 32'd3);
      checkOutput("rst_vga", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
      resetDut();

      // ---- basic body of three segments ----
      doMove(0, 0, 1'b0, "basic_m0");
      doMove(20, 0, 1'b0, "basic_m1");
      doMove(40, 0, 1'b0, "basic_m2");
      doMove(60, 0, 1'b0, "basic_m3");
      checkOutput("basic_len", {27'd0, body_len}, 32'd3);
      probePixel(59, 0, 1'b1, "pix_59_0");
      probePixel(60, 0, 1'b0, "pix_60_0_head");
      probePixel(0, 19, 1'b1, "pix_0_19");
      probePixel(0, 20, 1'b0, "pix_0_20");
      probePixel(30, 10, 1'b1, "pix_30_10");

      // ---- growth, coincident grow+move, saturation ----
      resetDut();
      for (int i = 0; i < 16; i++) doMove(20 * i, 200, 1'b0, "fill");
      doMove(320, 200, 1'b1, "grow_move");
      checkOutput("grow_move_len", {27'd0, body_len}, 32'd4);
      for (int i = 0; i < 20; i++) pulseGrow();
      checkOutput("grow_sat_len", {27'd0, body_len}, 32'd15);
      pulseGrow();
      checkOutput("grow_sat_hold", {27'd0, body_len}, 32'd15);
      doMove(340, 200, 1'b0, "full_scan");
      probePixel(40, 210, 1'b1, "pix_oldest_seg");
      probePixel(20, 210, 1'b0, "pix_beyond_tail");

      // ---- self-loop collision, then reset in the middle of a scan ----
      resetDut();
      pulseGrow();
      checkOutput("loop_len", {27'd0, body_len}, 32'd4);
      doMove(0, 0, 1'b0, "loop_m0");
      doMove(20, 0, 1'b0, "loop_m1");
      doMove(20, 20, 1'b0, "loop_m2");
      doMove(0, 20, 1'b0, "loop_m3");
      doMove(0, 0, 1'b0, "loop_hit");
      checkOutput("loop_hit_flag", {31'd0, self_hit}, 32'd1);
      doMove(0, 40, 1'b0, "loop_sticky");
      x = 12'd1;
      y = 12'd41;
      applyStimulus(0, 60, 1'b0);
      @(negedge CLOCK_50);
      checkOutput("midrst_pre_busy", {31'd0, busy}, 32'd1);
      checkOutput("midrst_pre_vga", {8'h00, vga_r, vga_g, vga_b}, 32'h00C000);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_hit", {31'd0, self_hit}, 32'd0);
      checkOutput("midrst_vga", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
      checkOutput("midrst_len", {27'd0, body_len}, 32'd3);
      resetDut();

      // ---- pointer wrap: 40 moves in a straight line ----
      for (int i = 0; i < 40; i++) doMove(20 * i, 100, 1'b0, "wrap");
      checkOutput("wrap_hit", {31'd0, self_hit}, 32'd0);
      probePixel(760, 100, 1'b1, "wrap_age1");
      probePixel(720, 119, 1'b1, "wrap_age3");
      probePixel(739, 110, 1'b1, "wrap_age3_edge");
      probePixel(719, 100, 1'b0, "wrap_age4");
      probePixel(780, 100, 1'b0, "wrap_head");
      probePixel(760, 120, 1'b0, "wrap_below");

      // ---- restart: second move one cycle into a scan ----
      resetDut();
      doMove(0, 0, 1'b0, "rs_m0");
      doMove(20, 0, 1'b0, "rs_m1");
      doMove(40, 0, 1'b0, "rs_m2");
      doMove(60, 0, 1'b0, "rs_m3");
      applyStimulus(80, 0, 1'b0);
      checkOutput("restart_busy_pre", {31'd0, busy}, 32'd1);
      stale = busyQ.pop_front();
      applyStimulus(60, 0, 1'b0);
      waitScan("restart");
      checkOutput("restart_hit_flag", {31'd0, self_hit}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
